// File: rtl/shift_seq.sv
// shift_seq: iterative EX-stage shifter, at most STEP bits per cycle, with stall and ready/start handshake.
module shift_seq #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        annul,
    input  logic [1:0]  op,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    output logic        stallreq,
    output logic        busy,
    output logic        ready,
    output logic [31:0] result
);
    localparam logic [5:0] LSTEP = 6'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_work, r_result, w_shifted;
    logic [5:0]  r_rem, w_k, w_rem_nxt;
    logic [1:0]  r_op;
    logic        w_accept, w_pass;

    assign w_k       = (r_rem > LSTEP) ? LSTEP : r_rem;
    assign w_rem_nxt = r_rem - w_k;
    assign w_pass    = (shamt == 5'd0) || (op == 2'b10);
    assign w_shifted = (r_op == 2'b00) ? r_work << w_k :
                       (r_op == 2'b01) ? r_work >> w_k :
                       32'($signed(r_work) >>> w_k);

    assign busy     = r_state == SHIFT;
    assign ready    = r_state == DONE;
    assign stallreq = (r_state == IDLE && start && !annul) || r_state == SHIFT;
    assign result   = r_result;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        if (annul) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_accept = start;
                    w_next   = !start ? IDLE : (w_pass ? DONE : SHIFT);
                end
                SHIFT:   w_next = (w_rem_nxt == 6'd0) ? DONE : SHIFT;
                DONE:    w_next = start ? DONE : IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // result only moves on entry to DONE, so neither annul nor reset exposes a partial value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_work   <= '0;
            r_rem    <= '0;
            r_op     <= '0;
            r_result <= '0;
        end else if (annul) begin
            r_rem <= '0;
        end else if (w_accept) begin
            r_work <= data_in;
            r_op   <= op;
            r_rem  <= w_pass ? 6'd0 : {1'b0, shamt};
            if (w_pass) r_result <= data_in;
        end else if (r_state == SHIFT) begin
            r_work <= w_shifted;
            r_rem  <= w_rem_nxt;
            if (w_rem_nxt == 6'd0) r_result <= w_shifted;
        end
    end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: three STEP variants against a transaction-level model, directed plus random stimulus.
module tb_shift_seq;
    logic        clk = 0, rst = 0, start = 0, annul = 0;
    logic [1:0]  op = 0;
    logic [31:0] data_in = 0;
    logic [4:0]  shamt = 0;
    logic        st[3], bz[3], rd[3];
    logic [31:0] rs[3];
    int          steps[3] = '{4, 1, 32};
    int          total = 0, bad = 0;
    int          m_cnt[3];
    logic        m_done[3];
    logic [31:0] m_res[3], m_pend[3];

    always #5 clk = ~clk;

    shift_seq #(.STEP(4)) u0 (.clk(clk), .rst(rst), .start(start), .annul(annul), .op(op),
        .data_in(data_in), .shamt(shamt), .stallreq(st[0]), .busy(bz[0]), .ready(rd[0]), .result(rs[0]));
    shift_seq #(.STEP(1)) u1 (.clk(clk), .rst(rst), .start(start), .annul(annul), .op(op),
        .data_in(data_in), .shamt(shamt), .stallreq(st[1]), .busy(bz[1]), .ready(rd[1]), .result(rs[1]));
    shift_seq #(.STEP(32)) u2 (.clk(clk), .rst(rst), .start(start), .annul(annul), .op(op),
        .data_in(data_in), .shamt(shamt), .stallreq(st[2]), .busy(bz[2]), .ready(rd[2]), .result(rs[2]));

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b11:   return $signed(d) >>> s;
            default: return d;
        endcase
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%h want=%h", name, i, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timeout t=%0t got=no_ready want=ready", name, $time);
    endtask

    // model: final value computed in one step, busy modelled as a countdown of ceil(shamt/STEP)
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                m_cnt[i] = 0; m_done[i] = 0; m_res[i] = 0; m_pend[i] = 0;
            end else if (annul) begin
                m_cnt[i] = 0; m_done[i] = 0;
            end else if (m_cnt[i] == 0 && !m_done[i]) begin
                if (start) begin
                    m_pend[i] = ref_shift(op, data_in, shamt);
                    if (shamt == 0 || op == 2'b10) begin
                        m_done[i] = 1; m_res[i] = m_pend[i];
                    end else m_cnt[i] = (int'(shamt) + steps[i] - 1) / steps[i];
                end
            end else if (m_cnt[i] > 0) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    m_done[i] = 1; m_res[i] = m_pend[i];
                end
            end else if (!start) m_done[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                chk("stallreq", i, 32'(st[i]), 32'((m_cnt[i] == 0 && !m_done[i] && start && !annul) || m_cnt[i] > 0));
                chk("busy", i, 32'(bz[i]), 32'(m_cnt[i] > 0));
                chk("ready", i, 32'(rd[i]), 32'(m_done[i]));
                chk("result", i, rs[i], m_res[i]);
            end
        end
    end

    task automatic req(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                       input logic [31:0] want, input int nst);
        int n = 0;
        bit ok = 0;
        @(posedge clk); #1;
        op = o; data_in = d; shamt = s; start = 1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (rd[0]) ok = 1;
            else if (st[0]) n++;
        end
        if (ok) chk("stall_cycles", 0, 32'(n), 32'(nst));
        else timeout("req_step4");
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            if (rd[0] && rd[1] && rd[2]) ok = 1;
            else @(negedge clk);
        end
        if (!ok) timeout("req_all");
        for (int i = 0; i < 3; i++) chk("req_result", i, rs[i], want);
        @(posedge clk); #1 start = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) chk("idle_after_drop", i, 32'(rd[i]), 32'd0);
    endtask

    initial begin
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_result", i, rs[i], 32'd0);
            chk("rst_ready", i, 32'(rd[i]), 32'd0);
            chk("rst_busy", i, 32'(bz[i]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1;
        req(2'b00, 32'h01010101, 5'd2, 32'h04040404, 2);
        req(2'b11, 32'h80800000, 5'd16, 32'hFFFF8080, 5);
        req(2'b11, 32'h80800000, 5'd24, 32'hFFFFFF80, 7);
        req(2'b01, 32'h80800000, 5'd16, 32'h00008080, 5);
        req(2'b01, 32'h04040404, 5'd5, 32'h00202020, 3);
        req(2'b10, 32'hCAFEF00D, 5'd7, 32'hCAFEF00D, 1);
        req(2'b00, 32'h12345678, 5'd0, 32'h12345678, 1);
        @(posedge clk); #1;
        op = 2'b00; data_in = 32'h1; shamt = 5'd20; start = 1;
        @(posedge clk);
        @(posedge clk); #1;
        annul = 1; start = 0;
        @(posedge clk); #1;
        annul = 0;
        chk("annul_busy", 0, 32'(bz[0]), 32'd0);
        chk("annul_ready", 0, 32'(rd[0]), 32'd0);
        chk("annul_result", 0, rs[0], 32'h12345678);
        chk("annul_result", 1, rs[1], 32'h12345678);
        req(2'b00, 32'h1, 5'd4, 32'h00000010, 2);
        @(posedge clk); #1;
        op = 2'b11; data_in = 32'h80000000; shamt = 5'd20; start = 1;
        @(posedge clk);
        @(posedge clk); #2;
        chk("pre_rst_busy", 0, 32'(bz[0]), 32'd1);
        rst = 0; start = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("async_busy", i, 32'(bz[i]), 32'd0);
            chk("async_ready", i, 32'(rd[i]), 32'd0);
            chk("async_result", i, rs[i], 32'd0);
        end
        @(posedge clk); #3 rst = 1;
        req(2'b11, 32'hF0000000, 5'd4, 32'hFF000000, 2);
        repeat (3000) begin
            @(posedge clk); #1;
            start   = ($urandom % 10) < 7;
            annul   = ($urandom % 20) == 0;
            op      = 2'($urandom);
            data_in = $urandom;
            shamt   = 5'($urandom);
        end
        @(posedge clk); #1;
        start = 0; annul = 0;
        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
